// File: rtl/pat_stream_pkg.sv
// Shared definitions for the pattern stream controller: FSM state encoding
// and default parameter values.
package pat_stream_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PAT_W  = 4;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pat_stream_ctrl_match.sv
// Overlapping serial pattern matcher. Keeps a PAT_W-bit history, a fill
// counter so no match is reported before PAT_W bits have arrived, and a
// saturating match counter. hit is a registered one-cycle pulse.
module pat_match
  import pat_stream_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             bit_vld,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit,
  output logic [CNT_W-1:0] match_count
);

  localparam int                  FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hit_q, hit_d;

  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_shift;
  logic              match;

  // Next history/fill/count; a match compares the history including this bit.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    hist_d     = hist_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    hit_d      = 1'b0;
    hist_shift = PAT_W'({hist_q, bit_in});
    fill_shift = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
    match      = bit_vld && (hist_shift == pattern) && (fill_shift == FILL_MAX);

    if (clr) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (bit_vld) begin
      hist_d = hist_shift;
      fill_d = fill_shift;
      hit_d  = match;
      if (match && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Matcher state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
    end
  end

  assign hit         = hit_q;
  assign match_count = cnt_q;

endmodule

// File: rtl/pat_stream_ctrl.sv
// Frame controller: accepts words over valid/ready, serializes them MSB
// first into the pattern matcher, and ends the frame after cfg_words words
// with a one-cycle done pulse.
module pat_stream_ctrl
  import pat_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [CNT_W-1:0]  cfg_words,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              hit,
  output logic              done,
  output logic [CNT_W-1:0]  match_count
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  words_left_q, words_left_d;
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic              clr;
  logic              bit_vld;

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    words_left_d = words_left_q;
    pattern_d    = pattern_q;
    clr          = 1'b0;
    bit_vld      = 1'b0;
    in_ready     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          pattern_d    = cfg_pattern;
          words_left_d = cfg_words;
          clr          = 1'b1;
          state_d      = (cfg_words == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d   = in_data;
          bit_idx_d = IDX_W'(DATA_W - 1);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bit_vld = 1'b1;
        shreg_d = shreg_q << 1;
        if (bit_idx_q == '0) begin
          words_left_d = words_left_q - CNT_W'(1);
          state_d      = (words_left_q == CNT_W'(1)) ? ST_DONE : ST_LOAD;
        end else begin
          bit_idx_d = bit_idx_q - IDX_W'(1);
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data-path registers are reset too, although their contents
    // are don't-care in IDLE; this keeps simulation X-free after reset.
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      words_left_q <= '0;
      pattern_q    <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      words_left_q <= words_left_d;
      pattern_q    <= pattern_d;
    end
  end

  pat_match #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) u_match (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .bit_vld     (bit_vld),
    .bit_in      (shreg_q[DATA_W-1]),
    .pattern     (pattern_q),
    .hit         (hit),
    .match_count (match_count)
  );

endmodule

// File: tb/tb_pat_stream_ctrl.sv
// Self-checking bench for pat_stream_ctrl. Two instances share stimulus: the
// default configuration and a CNT_W=2 copy for saturation behaviour.
module tb_pat_stream_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] cfg_pattern;
  logic [7:0] cfg_words;
  logic       in_valid;
  logic [7:0] in_data;

  logic       in_ready, busy, hit, done;
  logic [7:0] match_count;
  logic       s_in_ready, s_busy, s_hit, s_done;
  logic [1:0] s_match_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] w   [64];
  int         stl [64];

  pat_stream_ctrl u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_pattern (cfg_pattern),
    .cfg_words   (cfg_words),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .busy        (busy),
    .hit         (hit),
    .done        (done),
    .match_count (match_count)
  );

  pat_stream_ctrl #(.CNT_W(2)) u_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_pattern (cfg_pattern),
    .cfg_words   (cfg_words[1:0]),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (s_in_ready),
    .busy        (s_busy),
    .hit         (s_hit),
    .done        (s_done),
    .match_count (s_match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic clear_stalls();
    for (int i = 0; i < 64; i++) stl[i] = 0;
  endtask

  // Runs one frame of n words (w[], stl[]) and checks every cycle against a
  // model derived from the bit stream and the frame timing rules.
  // cfg_words of u_sat only sees the low two bits, so n is kept below 4
  // whenever u_sat's frame must agree (all callers keep n in 0..3).
  task automatic run_frame(input logic [3:0] pat, input int n, input bit inject_start);
    bit         eh [0:1023];
    int         acc [64];
    int         done_edge;
    int         a, nbits, cnt;
    logic [3:0] win;
    bit         load_c;

    for (int i = 0; i < 1024; i++) eh[i] = 1'b0;
    win = '0; nbits = 0; a = 0;
    for (int k = 0; k < n; k++) begin
      a = a + ((k == 0) ? 1 : 9) + stl[k];
      acc[k] = a;
      for (int j = 0; j < 8; j++) begin
        win = {win[2:0], w[k][7-j]};
        nbits++;
        if (nbits >= 4 && win == pat) eh[a + 1 + j] = 1'b1;
      end
    end
    done_edge = (n == 0) ? 0 : acc[n-1] + 8;

    @(negedge clk);
    start       = 1'b1;
    cfg_pattern = pat;
    cfg_words   = 8'(n);
    in_valid    = 1'b0;
    @(posedge clk);
    cnt = 0;
    for (int e = 0; e <= done_edge + 1; e++) begin
      @(negedge clk);
      if (eh[e]) cnt++;
      load_c = 1'b0;
      for (int k = 0; k < n; k++)
        if ((e + 1 >= acc[k] - stl[k]) && (e + 1 <= acc[k])) load_c = 1'b1;
      check("hit",       32'(hit),           32'(eh[e]));
      check("s_hit",     32'(s_hit),         32'(eh[e]));
      check("done",      32'(done),          32'(e == done_edge));
      check("busy",      32'(busy),          32'(e <= done_edge));
      check("in_ready",  32'(in_ready),      32'(load_c));
      check("count",     32'(match_count),   32'(sat(cnt, 255)));
      check("s_count",   32'(s_match_count), 32'(sat(cnt, 3)));
      start    = 1'b0;
      in_valid = 1'b0;
      if (inject_start && n > 0 && e == acc[0] + 2) begin
        start       = 1'b1;
        cfg_pattern = ~pat;
        cfg_words   = 8'd5;
      end
      for (int k = 0; k < n; k++)
        if (acc[k] == e + 1) begin
          in_valid = 1'b1;
          in_data  = w[k];
        end
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_pattern = '0; cfg_words = '0;
    in_valid = 1'b0; in_data = '0;
    clear_stalls();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",     32'(busy),        32'd0);
    check("rst_in_ready", 32'(in_ready),    32'd0);
    check("rst_hit",      32'(hit),         32'd0);
    check("rst_done",     32'(done),        32'd0);
    check("rst_count",    32'(match_count), 32'd0);
    rst_n = 1'b1;

    // Single word with two overlapping matches.
    w[0] = 8'b1001_0010;
    run_frame(4'b1001, 1, 1'b0);
    check("single_total", 32'(match_count), 32'd2);

    // Match spanning a word boundary.
    w[0] = 8'h01; w[1] = 8'h20;
    run_frame(4'b1001, 2, 1'b0);
    check("cross_total", 32'(match_count), 32'd1);

    // Fill gating, twice to show history is cleared on start.
    w[0] = 8'h00;
    run_frame(4'b0000, 1, 1'b0);
    check("fill_total_1", 32'(match_count), 32'd5);
    run_frame(4'b0000, 1, 1'b0);
    check("fill_total_2", 32'(match_count), 32'd5);

    // Saturation on the narrow counter: 13 hits, count stays at 3.
    w[0] = 8'h00; w[1] = 8'h00;
    run_frame(4'b0000, 2, 1'b0);
    check("sat_total",   32'(match_count),   32'd13);
    check("sat_s_total", 32'(s_match_count), 32'd3);

    // Empty frame.
    run_frame(4'b1111, 0, 1'b0);
    check("zero_total", 32'(match_count), 32'd0);

    // Five stall cycles in LOAD before the first word, two before the second.
    w[0] = 8'b1001_1001; w[1] = 8'b0011_0010;
    stl[0] = 5; stl[1] = 2;
    run_frame(4'b1001, 2, 1'b0);
    clear_stalls();

    // start pulsed during SHIFT must be ignored.
    w[0] = 8'hA5; w[1] = 8'h3C;
    run_frame(4'b0101, 2, 1'b1);

    // Reset during the first word: after the first hit, before the frame ends.
    w[0] = 8'b1001_0010;
    @(negedge clk);
    start = 1'b1; cfg_pattern = 4'b1001; cfg_words = 8'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = w[0];
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_rst_hit",   32'(hit),         32'd1);
    check("pre_rst_count", 32'(match_count), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",     32'(busy),          32'd0);
    check("mid_rst_hit",      32'(hit),           32'd0);
    check("mid_rst_done",     32'(done),          32'd0);
    check("mid_rst_in_ready", 32'(in_ready),      32'd0);
    check("mid_rst_count",    32'(match_count),   32'd0);
    check("mid_rst_s_count",  32'(s_match_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    run_frame(4'b1001, 1, 1'b0);
    check("post_rst_total", 32'(match_count), 32'd2);

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      int n;
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) begin
        w[k]   = 8'($urandom);
        stl[k] = int'($urandom_range(0, 3));
      end
      run_frame(4'($urandom), n, 1'b0);
      clear_stalls();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
